// File: rtl/ring_sched_pkg.sv
// Shared types and sizing for the ring round-robin scheduler.
// The hold counter holds values 0..MAX_HOLD inclusive, hence $clog2(MAX_HOLD+1).
package ring_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_MAX_HOLD = 8;
    localparam int HOLD_W       = $clog2(DEF_MAX_HOLD + 1);

    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above the token,
// wrapping, found by a lowest-set-bit scan over a double-width request vector.
module rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] token,
    output logic [WIDTH-1:0] winner
);

    localparam int DW = 2 * WIDTH;

    logic [WIDTH-1:0] mask_hi;
    logic [DW-1:0]    dbl;
    logic [DW-1:0]    iso;

    // Lower copy keeps only bits at or above the token; the upper copy covers the wrap.
    always_comb begin
        mask_hi = ~(token - WIDTH'(1));
        dbl     = {req, req & mask_hi};
        iso     = dbl & (~dbl + DW'(1));
        winner  = iso[WIDTH-1:0] | iso[DW-1:WIDTH];
    end

endmodule

// File: rtl/ring_rr_sched.sv
// Round-robin scheduler with a one-hot rotating token: one registered grant at a
// time, released on done, withdrawal or hold-limit timeout.
module ring_rr_sched
    import ring_sched_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] done,
    output logic [WIDTH-1:0] gnt,
    output logic [WIDTH-1:0] token,
    output logic             busy,
    output logic             timeout
);

    localparam int HW = hold_cnt_w(MAX_HOLD);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] token_q, token_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] winner;
    logic             rel_done, rel_wdraw, rel_limit;

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req    (req),
        .token  (token_q),
        .winner (winner)
    );

    assign rel_done  = |(done & gnt_q);
    assign rel_wdraw = ~|(req & gnt_q);
    assign rel_limit = (hold_q == HW'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        token_d   = token_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = winner;
                    hold_d  = HW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_wdraw || rel_limit) begin
                    gnt_d     = '0;
                    token_d   = {gnt_q[WIDTH-2:0], gnt_q[WIDTH-1]};
                    hold_d    = '0;
                    state_d   = IDLE;
                    // A done or withdrawal on the limit edge counts as a normal release.
                    timeout_d = rel_limit && !rel_done && !rel_wdraw;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            token_q   <= WIDTH'(1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            token_q   <= token_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign token   = token_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_sched.sv
// Scoreboard bench for ring_rr_sched: stimulus pushes the hand-computed state
// expected after each edge, a monitor pops and compares one entry per cycle.
module tb_ring_rr_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [3:0] token;
    logic       busy;
    logic       timeout;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [3:0] tok;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    ring_rr_sched #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .token   (token),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] dn, input logic [3:0] eg,
                        input logic [3:0] et, input logic eto);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        e.tag = tag;
        e.gnt = eg;
        e.tok = et;
        e.to  = eto;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry describes the outputs after the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (gnt !== e.gnt || token !== e.tok || timeout !== e.to || busy !== (|e.gnt)) begin
                    n_bad++;
                    $display("FAIL %s: got gnt=%b token=%b busy=%b timeout=%b, want gnt=%b token=%b busy=%b timeout=%b",
                             e.tag, gnt, token, busy, timeout, e.gnt, e.tok, |e.gnt, e.to);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;

        // 1. reset with all requests asserted
        step("rst0", 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0);
        step("rst1", 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0);

        // 2. single request then done
        step("single_gnt",  0, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 0);
        step("single_done", 0, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 0);
        step("single_idle", 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0);

        // 3. fairness from a fresh token
        step("fair_rst", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0);
        step("fair_g0",  0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 0);
        step("fair_r0",  0, 4'b1111, 4'b0001, 4'b0000, 4'b0010, 0);
        step("fair_g1",  0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 0);
        step("fair_ign", 0, 4'b1111, 4'b1101, 4'b0010, 4'b0010, 0);
        step("fair_r1",  0, 4'b1111, 4'b0010, 4'b0000, 4'b0100, 0);
        step("fair_g2",  0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0);
        step("fair_r2",  0, 4'b1111, 4'b0100, 4'b0000, 4'b1000, 0);
        step("fair_g3",  0, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 0);
        step("fair_r3",  0, 4'b1111, 4'b1000, 4'b0000, 4'b0001, 0);
        step("fair_g4",  0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 0);
        step("fair_r4",  0, 4'b1111, 4'b0001, 4'b0000, 4'b0010, 0);
        step("fair_end", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0);

        // 4. timeout after exactly 8 granted cycles
        for (int i = 0; i < 8; i++)
            step($sformatf("to_hold%0d", i + 1), 0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 0);
        step("to_pulse",  0, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 1);
        step("to_regnt",  0, 4'b0010, 4'b0000, 4'b0010, 4'b0100, 0);
        step("to_wdraw",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0);

        // done on the limit edge is a normal release
        for (int i = 0; i < 8; i++)
            step($sformatf("lim_hold%0d", i + 1), 0, 4'b0001, 4'b0000, 4'b0001, 4'b0100, 0);
        step("lim_done", 0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 0);
        step("lim_idle", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0);

        // 5. wrap and withdraw: first move token to 1000
        step("wr_g2",    0, 4'b0100, 4'b0000, 4'b0100, 4'b0010, 0);
        step("wr_r2",    0, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 0);
        step("wr_wrap",  0, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 0);
        step("wr_drop",  0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0);
        step("wr_next",  0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 0);
        step("wr_drop2", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0);
        step("wr_idle",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0);

        // 6. reset during the third grant cycle
        step("mid_c1",   0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 0);
        step("mid_c2",   0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 0);
        step("mid_rst",  1, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 0);
        step("mid_scan", 0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 0);
        step("mid_rel",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_rr_sched.md
# ring_rr_sched

Round-robin scheduler that shares one resource between `WIDTH` requesters using a one-hot rotating token, the same ring pattern as the team's ring counter. It sits between the requesting blocks and the shared datapath. It issues exactly one registered grant at a time, releases on completion or timeout, and advances the token past the last winner so service is fair.

## Interface

Parameters:
- `WIDTH`, 4, number of requesters and token ring length (≥2)
- `MAX_HOLD`, 8, maximum consecutive cycles one grant may be held (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req`  in  WIDTH  level request per requester
- `done`  in  WIDTH  completion pulse per requester; only the granted bit is used
- `gnt`  out  WIDTH  one-hot or zero grant, registered
- `token`  out  WIDTH  one-hot ring pointer to the highest-priority requester for the next arbitration
- `busy`  out  1  high while a grant is held (`gnt != 0`)
- `timeout`  out  1  one-cycle pulse when a grant is force-released by the hold limit

## Operation

- Reset values:
  - `gnt = 0`
  - `token = 1` (bit 0 set)
  - `busy = 0`
  - `timeout = 0`
  - hold counter `= 0`
  - state `IDLE`
- **IDLE state:**
  - If `req == 0`, the scheduler stays in `IDLE` and the token does not move.
  - Otherwise it picks the first set `req` bit, scanning from the token position upward and wrapping from bit `WIDTH-1` to bit 0.
  - Next edge: `gnt` = winner one-hot, hold counter = 1, state goes to `GRANT`.
- **GRANT state.** Release occurs on the first edge where any of these holds:
  - (a) `done & gnt != 0`
  - (b) `req & gnt == 0` (requester withdrew)
  - (c) hold counter `== MAX_HOLD`
- **On release:**
  - `gnt` is set to 0.
  - `token` is set to `gnt` rotated left by one; bit `WIDTH-1` wraps to bit 0.
  - State returns to `IDLE`.
  - `timeout` is set to 1 only when (c) is the sole cause.
- **No release:** the hold counter increments.
- `done` bits of non-granted requesters are ignored in all states.
- Simultaneous (a) and (c): treat as a normal release, with `timeout = 0`.
- Width rules:
  - The hold counter is `$clog2(MAX_HOLD+1)` bits.
  - `MAX_HOLD` is never exceeded, so the counter never wraps.
- Reset mid-grant: the next edge restores all reset values. No `timeout` pulse is issued and the token is not rotated.

## Timing

- Request-to-grant latency is one edge. A `req` that is stable before edge E gives `gnt` high after E.
- Release latency is one edge. A `done` sampled at edge E gives `gnt` low and the new `token` after E.
- There is a mandatory idle cycle between consecutive grants. The earliest next grant comes after edge E+1.
- A single requester holding `req` continuously with no `done` gets `gnt` high for exactly `MAX_HOLD` cycles.
- After that forced release it may be re-granted after the idle cycle, if it is still first in scan order.
- `timeout` is high for exactly the one cycle following the release edge.
- `busy` is combinationally equal to `|gnt` and is not separately registered.

## Structure

- Shared package `ring_sched_pkg` contains:
  - state enum `{IDLE, GRANT}`
  - localparam for the hold-counter width
- Sub-module `rr_pick`: combinational, input `req` and `token`, output one-hot winner. Implement it as a double-width priority scan masked by the token.
- The top level holds:
  - state register
  - `gnt` register
  - `token` ring register
  - hold counter
  - `timeout` register

## Test plan

All scenarios use `WIDTH=4`, `MAX_HOLD=8`.

1. **Reset:** hold `rst=1` for 2 edges with `req=1111` → `gnt=0000`, `token=0001`, `busy=0`, `timeout=0` throughout.
2. **Single request:** `token=0001`, `req=0100` → `gnt=0100` one edge later. Then `done=0100` pulse → `gnt=0000`, `token=1000` after that edge.
3. **Fairness:** `req=1111` held, each winner pulses its `done` on its first grant cycle → grant sequence `0001`, `0010`, `0100`, `1000`, `0001`, with one `gnt=0000` cycle between each.
4. **Timeout:** `req=0010` held, `done=0` → `gnt=0010` for exactly 8 cycles, then `timeout=1` for 1 cycle, `gnt=0000`, `token=0100`.
5. **Wrap and withdraw:**
   - `token=1000`, `req=0011` → `gnt=0001`.
   - Then `req[0]` drops → `gnt=0000`, `token=0010`, `timeout=0`.
6. **Reset mid-grant:** assert `rst` at the 3rd cycle of `gnt=0100` → next edge gives `gnt=0000`, `token=0001`, `timeout=0`. The first grant after reset follows scan order from bit 0.
